// File: rtl/harvard_bus_bridge.sv
// harvard_bus_bridge: serialises the core's fetch and data access onto one
// Avalon-MM bus and advances the core one clock per completed step.
//
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   cpu_clk_enable             one-cycle pulse per core step (high in reset)
//   cpu_active                 core running flag; low parks the bridge
//   cpu_instr_address/readdata fetch address and latched instruction word
//   cpu_data_address/read/write/writedata/readdata
//                              core data port and latched data word
//   avm_*                      Avalon-MM master port (full-word accesses)
//   bus_error                  sticky waitrequest timeout flag
module harvard_bus_bridge #(
  parameter bit          SKIP_REFETCH = 1'b1,
  parameter int unsigned WAIT_LIMIT   = 0
)(
  input  logic        clk,
  input  logic        reset,
  output logic        cpu_clk_enable,
  input  logic        cpu_active,
  input  logic [31:0] cpu_instr_address,
  output logic [31:0] cpu_instr_readdata,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_DATA_RD,
    S_DATA_WR,
    S_STEP,
    S_HALT
  } state_t;

  localparam logic [31:0] WLIM = WAIT_LIMIT[31:0];

  state_t      state, state_nx;
  logic [31:0] ireg, dreg, iaddr_q;
  logic        ivalid;
  logic [31:0] wait_cnt;
  logic        hit, strobe, accept, timeout;

  assign hit = SKIP_REFETCH && ivalid
            && (cpu_instr_address == iaddr_q);

  // Strobes are decoded from state; the core is stalled while the
  // bridge is busy, so its address/data inputs are stable here.
  always_comb begin
    state_nx      = state;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = 32'h0;
    avm_writedata = 32'h0;
    unique case (state)
      S_RST:   state_nx = S_FETCH;
      S_FETCH: begin
        if (!cpu_active) begin
          state_nx = S_HALT;
        end else if (hit) begin
          state_nx = S_DECODE;
        end else begin
          avm_read    = 1'b1;
          avm_address = cpu_instr_address;
          if (!avm_waitrequest) state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cpu_data_read)       state_nx = S_DATA_RD;
        else if (cpu_data_write) state_nx = S_DATA_WR;
        else                     state_nx = S_STEP;
      end
      S_DATA_RD: begin
        avm_read    = 1'b1;
        avm_address = cpu_data_address;
        if (!avm_waitrequest)
          state_nx = cpu_data_write ? S_DATA_WR : S_STEP;
      end
      S_DATA_WR: begin
        avm_write     = 1'b1;
        avm_address   = cpu_data_address;
        avm_writedata = cpu_data_writedata;
        if (!avm_waitrequest) state_nx = S_STEP;
      end
      S_STEP:  state_nx = S_FETCH;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_RST;
    endcase
    strobe  = avm_read | avm_write;
    accept  = strobe & ~avm_waitrequest;
    // Timeout fires on the WAIT_LIMIT-th stalled cycle; strobes
    // drop on the following cycle once HALT is entered.
    timeout = (WLIM != 32'd0) && strobe && avm_waitrequest
           && (wait_cnt == WLIM - 32'd1);
    if (timeout) state_nx = S_HALT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_RST;
      ireg      <= 32'h0;
      dreg      <= 32'h0;
      iaddr_q   <= 32'h0;
      ivalid    <= 1'b0;
      wait_cnt  <= 32'h0;
      bus_error <= 1'b0;
    end else begin
      state <= state_nx;
      if (timeout) bus_error <= 1'b1;
      if (accept || !strobe) wait_cnt <= 32'h0;
      else                   wait_cnt <= wait_cnt + 32'd1;
      if (accept && state == S_FETCH) begin
        ireg    <= avm_readdata;
        iaddr_q <= cpu_instr_address;
        ivalid  <= 1'b1;
      end
      if (accept && state == S_DATA_RD)
        dreg <= avm_readdata;
      // A store over the cached instruction word forces a refetch.
      if (accept && state == S_DATA_WR
          && cpu_data_address[31:2] == iaddr_q[31:2])
        ivalid <= 1'b0;
    end
  end

  assign cpu_clk_enable     = reset | (state == S_STEP);
  assign cpu_instr_readdata = ireg;
  assign cpu_data_readdata  = dreg;
  assign avm_byteenable     = 4'hF;

endmodule

// File: tb/tb_harvard_bus_bridge.sv
// tb_harvard_bus_bridge: plays the core and a waitrequest memory around
// the bridge and checks each step against a transaction-level model.
module tb_harvard_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_clk_enable;
  logic        cpu_active;
  logic [31:0] cpu_instr_address;
  logic [31:0] cpu_instr_readdata;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        bus_error;

  harvard_bus_bridge #(
    .SKIP_REFETCH(1'b1),
    .WAIT_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset(rst),
    .cpu_clk_enable(cpu_clk_enable),
    .cpu_active(cpu_active),
    .cpu_instr_address(cpu_instr_address),
    .cpu_instr_readdata(cpu_instr_readdata),
    .cpu_data_address(cpu_data_address),
    .cpu_data_read(cpu_data_read),
    .cpu_data_write(cpu_data_write),
    .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata(cpu_data_readdata),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  int   tests = 0;
  int   fails = 0;
  txn_t obs_q[$];
  txn_t exp_q[$];

  logic [31:0] bmem   [logic [31:0]];
  logic [31:0] refmem [logic [31:0]];

  bit  stuck = 1'b0;
  int  force_wait = -1;
  int  waits_total = 0;

  bit          m_ivalid;
  logic [31:0] m_iaddr, m_ireg, m_dreg;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refmem.exists(a) ? refmem[a] : init_val(a);
  endfunction

  // Memory responder: decides waitrequest/readdata at each negedge so
  // the bridge samples a settled value at the following posedge.
  bit          busy = 1'b0;
  int          left = 0;
  logic [31:0] cur_addr;
  always @(negedge clk) begin
    if (rst || !(avm_read || avm_write)) begin
      busy = 1'b0;
      avm_waitrequest = 1'b0;
    end else begin
      chk("one_strobe", {31'h0, avm_read & avm_write}, 32'h0);
      chk("byteenable", {28'h0, avm_byteenable}, 32'hF);
      if (!busy) begin
        busy = 1'b1;
        cur_addr = avm_address;
        if (stuck)                left = 1000;
        else if (force_wait >= 0) left = force_wait;
        else                      left = $urandom_range(0, 2);
      end else begin
        chk("addr_stable", avm_address, cur_addr);
      end
      if (stuck || left > 0) begin
        left--;
        waits_total++;
        avm_waitrequest = 1'b1;
        avm_readdata = $urandom;
      end else begin
        avm_waitrequest = 1'b0;
        busy = 1'b0;
        if (avm_read) begin
          avm_readdata = bmem.exists(avm_address)
                       ? bmem[avm_address] : init_val(avm_address);
          obs_q.push_back('{1'b0, avm_address, avm_readdata});
        end else begin
          bmem[avm_address] = avm_writedata;
          obs_q.push_back('{1'b1, avm_address, avm_writedata});
        end
      end
    end
  end

  // One core step: model the expected bus traffic and latched words,
  // then wait for the step pulse and compare.
  task automatic do_step(input logic [31:0] ia, input logic rd,
                         input logic wr, input logic [31:0] da,
                         input logic [31:0] wd);
    int  cyc, w0, nd;
    bit  got;
    obs_q.delete();
    exp_q.delete();
    cpu_instr_address  = ia;
    cpu_data_read      = rd;
    cpu_data_write     = wr;
    cpu_data_address   = da;
    cpu_data_writedata = wd;
    if (!(m_ivalid && ia == m_iaddr)) begin
      m_ireg   = ref_rd(ia);
      m_iaddr  = ia;
      m_ivalid = 1'b1;
      exp_q.push_back('{1'b0, ia, m_ireg});
    end
    if (rd) begin
      m_dreg = ref_rd(da);
      exp_q.push_back('{1'b0, da, m_dreg});
    end
    if (wr) begin
      refmem[da] = wd;
      if (da[31:2] == m_iaddr[31:2]) m_ivalid = 1'b0;
      exp_q.push_back('{1'b1, da, wd});
    end
    nd  = int'(rd) + int'(wr);
    w0  = waits_total;
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (cpu_clk_enable) begin
        got = 1'b1;
        break;
      end
    end
    chk("step_pulse", {31'h0, got}, 32'h1);
    chk("step_cycles", cyc, 3 + nd + (waits_total - w0));
    chk("instr_rdata", cpu_instr_readdata, m_ireg);
    chk("data_rdata", cpu_data_readdata, m_dreg);
    chk("txn_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk("txn_kind", {31'h0, obs_q[i].wr}, {31'h0, exp_q[i].wr});
      chk("txn_addr", obs_q[i].addr, exp_q[i].addr);
      chk("txn_data", obs_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic model_reset();
    m_ivalid = 1'b0;
    m_iaddr  = 32'h0;
    m_ireg   = 32'h0;
    m_dreg   = 32'h0;
  endtask

  logic [31:0] wd, ia, da;
  logic [31:0] ipool [3];
  logic [31:0] dpool [5];
  int          n;

  initial begin
    rst = 1'b1;
    cpu_active = 1'b1;
    cpu_instr_address = 32'h0;
    cpu_data_address = 32'h0;
    cpu_data_read = 1'b0;
    cpu_data_write = 1'b0;
    cpu_data_writedata = 32'h0;
    model_reset();
    ipool = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008};
    dpool = '{32'h10, 32'h14, 32'h1000, 32'hBFC00000, 32'hBFC00004};

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_clk_en", {31'h0, cpu_clk_enable}, 32'h1);
      chk("rst_strobes", {30'h0, avm_read, avm_write}, 32'h0);
    end
    chk("rst_ireg", cpu_instr_readdata, 32'h0);
    chk("rst_dreg", cpu_data_readdata, 32'h0);
    chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
    rst = 1'b0;

    force_wait = 0;
    do_step(32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0);
    do_step(32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0);

    force_wait = 2;
    bmem[32'h1000]   = 32'hDEADBEEF;
    refmem[32'h1000] = 32'hDEADBEEF;
    do_step(32'hBFC00000, 1'b1, 1'b0, 32'h1000, 32'h0);
    chk("lw_deadbeef", cpu_data_readdata, 32'hDEADBEEF);
    force_wait = -1;

    do_step(32'hBFC00000, 1'b1, 1'b1, 32'h10, $urandom);

    wd = $urandom;
    do_step(32'hBFC00000, 1'b0, 1'b1, 32'hBFC00000, wd);
    do_step(32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("smc_refetch", cpu_instr_readdata, wd);

    for (int s = 0; s < 40; s++) begin
      ia = ipool[$urandom_range(0, 2)];
      da = dpool[$urandom_range(0, 4)];
      do_step(ia, 1'($urandom), 1'($urandom), da, $urandom);
    end

    stuck = 1'b1;
    cpu_instr_address = 32'h00002000;
    cpu_data_read  = 1'b0;
    cpu_data_write = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !bus_error; i++) begin
      @(negedge clk);
      chk("to_clk_en", {31'h0, cpu_clk_enable}, 32'h0);
      if (avm_read || avm_write) n++;
    end
    chk("to_wait_cycles", n, 4);
    chk("to_bus_error", {31'h0, bus_error}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk("halt_strobes", {30'h0, avm_read, avm_write}, 32'h0);
      chk("halt_clk_en", {31'h0, cpu_clk_enable}, 32'h0);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("areset_err", {31'h0, bus_error}, 32'h0);
    chk("areset_clk_en", {31'h0, cpu_clk_enable}, 32'h1);
    stuck = 1'b0;
    @(negedge clk);
    chk("areset_ireg", cpu_instr_readdata, 32'h0);
    rst = 1'b0;
    model_reset();
    do_step(32'hBFC00004, 1'b1, 1'b0, 32'h14, 32'h0);

    cpu_active = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_strobes", {30'h0, avm_read, avm_write}, 32'h0);
      chk("idle_clk_en", {31'h0, cpu_clk_enable}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/harvard_bus_bridge.md
Name: harvard_bus_bridge

Overview:
- Sits between the Harvard MIPS core (combinational instruction/data read ports, single-cycle write) and one shared Avalon-MM memory bus that has waitrequest.
- Serialises the instruction fetch and any data access onto the bus, latches the results, and presents them to the core.
- Advances the core exactly one clock per completed step by pulsing the core's clk_enable.

Parameters:
- SKIP_REFETCH, 1: if 1, skip the bus fetch when the instruction address equals the last fetched address and the latched word is valid.
- WAIT_LIMIT, 0: maximum consecutive waitrequest cycles in any bus state before a bus error; 0 disables the check.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cpu_clk_enable  output  1  clock enable to the core
- cpu_active  input  1  core active flag
- cpu_instr_address  input  32  core fetch address
- cpu_instr_readdata  output  32  latched instruction word
- cpu_data_address  input  32  core data address (word aligned)
- cpu_data_read  input  1  core data read request
- cpu_data_write  input  1  core data write request
- cpu_data_writedata  input  32  core store data
- cpu_data_readdata  output  32  latched data word
- avm_address  output  32  bus address
- avm_read  output  1  bus read strobe
- avm_write  output  1  bus write strobe
- avm_writedata  output  32  bus write data
- avm_byteenable  output  4  always 4'hF; the core performs read-modify-write for partial stores
- avm_waitrequest  input  1  bus stall
- avm_readdata  input  32  bus read data, valid in the cycle avm_waitrequest is low
- bus_error  output  1  sticky bus-timeout flag

Behaviour:
Reset:
- reset asynchronously forces state RST.
- avm_read, avm_write, bus_error go to 0; ireg, dreg, iaddr_q go to 0; ivalid goes to 0; the wait counter goes to 0.
- cpu_clk_enable = reset OR (state==STEP), so the core's synchronous reset is clocked while reset is high.
- Reset mid-transaction drops the strobes immediately; the aborted access is not resumed.

States: RST, FETCH, DECODE, DATA_RD, DATA_WR, STEP, HALT.
- RST: after reset deasserts, go to FETCH on the next clk.
- FETCH, core halted: if cpu_active==0, go to HALT with no bus access.
- FETCH, hit: if SKIP_REFETCH and ivalid and cpu_instr_address==iaddr_q, go to DECODE with no bus access.
- FETCH, miss: drive avm_read=1 and avm_address=cpu_instr_address, held stable. In the cycle avm_waitrequest==0: ireg<=avm_readdata, iaddr_q<=address, ivalid<=1, then go to DECODE.
- DECODE: cpu_instr_readdata=ireg is now stable, so the core's data request signals are valid.
  - If cpu_data_read, go to DATA_RD.
  - Else if cpu_data_write, go to DATA_WR.
  - Else go to STEP.
- DATA_RD: avm_read=1, address=cpu_data_address. When not waiting, dreg<=avm_readdata. Then go to DATA_WR if cpu_data_write (re-evaluated with the new dreg), else STEP.
- DATA_WR: avm_write=1, address=cpu_data_address, writedata=cpu_data_writedata. When not waiting, go to STEP.
  - If the written word address equals iaddr_q[31:2], clear ivalid (self-modifying code coherence).
- STEP: cpu_clk_enable=1 for exactly one cycle, then go to FETCH.
- HALT: no bus activity; cpu_clk_enable=0; stays until reset.

Outputs and counters:
- cpu_instr_readdata=ireg and cpu_data_readdata=dreg at all times. Both are 0 until first loaded.
- Strobes and address change only on state transitions. At most one of avm_read/avm_write is high in any cycle.
- Wait counter: increments each cycle a strobe is high with waitrequest==1; cleared on acceptance.
  - If WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT: bus_error<=1, strobes drop next cycle, go to HALT.

Latency per core step, with zero-wait memory:
- Fetch miss, no data access: 3 cycles.
- Fetch hit, no data access: 3 cycles (FETCH, DECODE, STEP).
- Each data access adds 1 cycle plus its wait cycles.

Test Plan:
1. Reset held 3 cycles -> cpu_clk_enable=1 for all 3, all avm strobes 0. After release, first bus read at 32'hBFC00000 with byteenable 4'hF.
2. Zero-wait memory, two core steps at the same instr_address 32'hBFC00000, SKIP_REFETCH=1 -> exactly one avm_read for the instruction. cpu_clk_enable pulses are 1 cycle wide and 3 cycles apart.
3. lw with data_read at 32'h00001000, memory returns 32'hDEADBEEF after 2 waitrequest cycles -> avm_address held stable across the wait, cpu_data_readdata=32'hDEADBEEF before the STEP pulse.
4. Core asserts both data_read and data_write (sb read-modify-write) at 32'h00000010 -> read precedes write, no overlapping strobes, avm_writedata equals cpu_data_writedata during the write.
5. Write to the word at iaddr_q, then next step at the same PC -> ivalid cleared and the instruction is re-fetched from the bus.
6. WAIT_LIMIT=4, waitrequest stuck at 1 -> bus_error=1 after 4 wait cycles, strobes 0, cpu_clk_enable stays 0. Async reset then clears bus_error.
